// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges the core's instruction-fetch and data ports onto a
// single req/gnt/rvalid memory port. Arbitration is combinational; an in-order
// ID FIFO routes each response back to the port that issued the request.
// Optional feature: define CORE_BUS_ARB_RR_EN for round-robin arbitration
// (default build: fixed priority, data beats instr).
module core_bus_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        protocol_err_o
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0]              count_q, count_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;      // 0 = instr, 1 = data
    logic                       proto_err_q, proto_err_d;

    logic full;
    logic data_win;
    logic push;
    logic pop;
    logic head_id;

    // Pointers wrap modulo MAX_OUTSTANDING, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign full = (count_q == CW'(MAX_OUTSTANDING));

`ifdef CORE_BUS_ARB_RR_EN
    logic prefer_data_q, prefer_data_d;

    // A lone requester always wins; on contention the port not granted last wins.
    assign data_win = data_req_i & (prefer_data_q | ~instr_req_i);

    // The preference flips only when a grant is actually accepted.
    always_comb begin
        prefer_data_d = prefer_data_q;
        if (push) prefer_data_d = ~data_win;
    end

    // Round-robin pointer; comes out of reset favouring data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prefer_data_q <= 1'b1;
        else        prefer_data_q <= prefer_data_d;
    end
`else
    assign data_win = data_req_i;
`endif

    // Request and grants are gated by rst_n so they read 0 while reset is held.
    assign mem_req_o   = rst_n & ~full & (instr_req_i | data_req_i);
    assign push        = mem_req_o & mem_gnt_i;
    assign data_gnt_o  = push & data_win;
    assign instr_gnt_o = push & ~data_win;

    // A response is only legitimate when something is outstanding.
    assign pop            = mem_rvalid_i & (count_q != '0);
    assign head_id        = id_q[rd_ptr_q];
    assign instr_rvalid_o = rst_n & pop & ~head_id;
    assign data_rvalid_o  = rst_n & pop & head_id;

    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;
    assign protocol_err_o = proto_err_q;

    // Address/control mux: the data port drives its own attributes, fetches are full-word reads.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = '0;
        if (data_win) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    // ID FIFO next state: push writes the winner at the tail, pop advances the head.
    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        id_d        = id_q;
        proto_err_d = proto_err_q | (mem_rvalid_i & (count_q == '0));
        if (push) begin
            id_d[wr_ptr_q] = data_win;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards anything still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            // NOTE: the ID store is only a few flops, so it is cleared with the rest of the state.
            id_q        <= '0;
            proto_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            id_q        <= id_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the arbiter. Honours
// CORE_BUS_ARB_RR_EN the same way the design does.
module tb_core_bus_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr, instr_rdata_o;
    logic        data_req, data_gnt_o, data_rvalid_o, data_we, data_err_o;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata_o;
    logic        mem_req_o, mem_gnt, mem_rvalid, mem_we_o, mem_err, protocol_err_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata;

    int checks   = 0;
    int failures = 0;

    // Reference model state: outstanding IDs in issue order, RR preference, sticky error.
    bit q[$];
    bit pref_data = 1'b1;
    bit perr      = 1'b0;
    bit last_gi   = 1'b0;
    bit last_gd   = 1'b0;

    core_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
        .protocol_err_o(protocol_err_o)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                         input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
                         input bit mg, input bit mrv, input logic [31:0] mrd, input bit merr);
        instr_req = ir;  instr_addr = ia;
        data_req = dr;   data_we = dwe; data_be = dbe; data_addr = da; data_wdata = dwd;
        mem_gnt = mg;    mem_rvalid = mrv; mem_rdata = mrd; mem_err = merr;
    endtask

    function automatic bit model_data_wins();
`ifdef CORE_BUS_ARB_RR_EN
        return data_req && (pref_data || !instr_req);
`else
        return data_req;
`endif
    endfunction

    // Check every output against the model for the inputs now applied, then advance the model.
    task automatic step();
        bit dw, mreq, pop, head;
        #2;
        dw   = model_data_wins();
        mreq = (q.size() < MAXO) && (instr_req || data_req);
        pop  = mem_rvalid && (q.size() > 0);
        head = pop ? q[0] : 1'b0;
        check("mem_req", 32'(mem_req_o), 32'(mreq));
        check("instr_gnt", 32'(instr_gnt_o), 32'(mreq && mem_gnt && !dw));
        check("data_gnt", 32'(data_gnt_o), 32'(mreq && mem_gnt && dw));
        if (mreq) begin
            check("mem_addr", mem_addr_o, dw ? data_addr : instr_addr);
            check("mem_we", 32'(mem_we_o), dw ? 32'(data_we) : 32'd0);
            check("mem_be", 32'(mem_be_o), dw ? 32'(data_be) : 32'hF);
            check("mem_wdata", mem_wdata_o, dw ? data_wdata : 32'd0);
        end
        check("instr_rvalid", 32'(instr_rvalid_o), 32'(pop && !head));
        check("data_rvalid", 32'(data_rvalid_o), 32'(pop && head));
        check("instr_rdata", instr_rdata_o, mem_rdata);
        check("data_rdata", data_rdata_o, mem_rdata);
        check("instr_err", 32'(instr_err_o), 32'(mem_err));
        check("data_err", 32'(data_err_o), 32'(mem_err));
        check("protocol_err", 32'(protocol_err_o), 32'(perr));
        last_gi = mreq && mem_gnt && !dw;
        last_gd = mreq && mem_gnt && dw;
        @(posedge clk);
        if (mem_rvalid && q.size() == 0) perr = 1'b1;
        if (pop) void'(q.pop_front());
        if (mreq && mem_gnt) begin
            q.push_back(dw);
            pref_data = !dw;
        end
        @(negedge clk);
    endtask

    // Assert reset mid-cycle with whatever inputs are applied; outputs must drop at once.
    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_instr_gnt", 32'(instr_gnt_o), 32'd0);
        check("rst_data_gnt", 32'(data_gnt_o), 32'd0);
        check("rst_instr_rvalid", 32'(instr_rvalid_o), 32'd0);
        check("rst_data_rvalid", 32'(data_rvalid_o), 32'd0);
        check("rst_protocol_err", 32'(protocol_err_o), 32'd0);
        q.delete();
        pref_data = 1'b1;
        perr      = 1'b0;
        last_gi   = 1'b0;
        last_gd   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // Fetch granted: full-word read.
        drive(1, 32'h80, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        check("A_instr_gnt", 32'(instr_gnt_o), 32'd1);
        check("A_mem_we", 32'(mem_we_o), 32'd0);
        check("A_mem_be", 32'(mem_be_o), 32'hF);
        step();
        // Its response comes back to the fetch port.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13, 0);
        #2;
        check("B_instr_rvalid", 32'(instr_rvalid_o), 32'd1);
        check("B_instr_rdata", instr_rdata_o, 32'h13);
        check("B_data_rvalid", 32'(data_rvalid_o), 32'd0);
        step();
        // Contention: data store wins (fixed, and RR right after a fetch grant).
        drive(1, 32'h84, 1, 1, 4'h3, 32'h100, 32'hDEADBEEF, 1, 0, 0, 0);
        #2;
        check("C_data_gnt", 32'(data_gnt_o), 32'd1);
        check("C_instr_gnt", 32'(instr_gnt_o), 32'd0);
        check("C_mem_we", 32'(mem_we_o), 32'd1);
        check("C_mem_be", 32'(mem_be_o), 32'h3);
        check("C_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        step();
        // Push and pop together at count 1: response to data, fetch granted.
        drive(1, 32'h84, 0, 0, 0, 0, 0, 1, 1, 32'h55, 1);
        #2;
        check("D_data_rvalid", 32'(data_rvalid_o), 32'd1);
        check("D_data_err", 32'(data_err_o), 32'd1);
        check("D_instr_gnt", 32'(instr_gnt_o), 32'd1);
        step();
        // Second outstanding (data), FIFO now full.
        drive(0, 0, 1, 0, 4'hF, 32'h200, 0, 1, 0, 0, 0);
        step();
        // Full: no request, no grant.
        drive(1, 32'h88, 1, 0, 4'hF, 32'h204, 0, 1, 0, 0, 0);
        #2;
        check("F_mem_req", 32'(mem_req_o), 32'd0);
        check("F_instr_gnt", 32'(instr_gnt_o), 32'd0);
        check("F_data_gnt", 32'(data_gnt_o), 32'd0);
        step();
        // Oldest response goes to instr; still full this cycle.
        drive(1, 32'h88, 0, 0, 0, 0, 0, 1, 1, 32'h77, 0);
        #2;
        check("G_instr_rvalid", 32'(instr_rvalid_o), 32'd1);
        check("G_data_rvalid", 32'(data_rvalid_o), 32'd0);
        step();
        // Room again: next request granted.
        drive(1, 32'h88, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        check("H_instr_gnt", 32'(instr_gnt_o), 32'd1);
        step();
        // Reset with two outstanding and everything asserted.
        drive(1, 32'h8C, 1, 0, 4'hF, 32'h300, 0, 1, 1, 0, 0);
        do_reset();
        // Stray response after reset.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0);
        #2;
        check("J_instr_rvalid", 32'(instr_rvalid_o), 32'd0);
        check("J_data_rvalid", 32'(data_rvalid_o), 32'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("K_protocol_err", 32'(protocol_err_o), 32'd1);
        step();
        step();
        do_reset();

        // Both held for four grants, responses keeping the FIFO from filling.
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h400, 1, 0, 4'hF, 32'h500, 0, 1, k > 0, 32'(k), 0);
            #2;
`ifdef CORE_BUS_ARB_RR_EN
            check("RR_data_gnt", 32'(data_gnt_o), 32'((k % 2) == 0));
            check("RR_instr_gnt", 32'(instr_gnt_o), 32'((k % 2) == 1));
`else
            check("FP_data_gnt", 32'(data_gnt_o), 32'd1);
            check("FP_instr_gnt", 32'(instr_gnt_o), 32'd0);
`endif
            step();
        end
        do_reset();

        // Randomized traffic; a refused request is held with stable attributes.
        for (int n = 0; n < 2000; n++) begin
            if (!(instr_req && !last_gi)) begin
                instr_req  = 1'($urandom_range(0, 1));
                instr_addr = $urandom;
            end
            if (!(data_req && !last_gd)) begin
                data_req   = 1'($urandom_range(0, 1));
                data_we    = 1'($urandom_range(0, 1));
                data_be    = 4'($urandom_range(0, 15));
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            mem_gnt    = ($urandom_range(0, 3) != 0);
            mem_rvalid = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) == 0);
            mem_rdata  = $urandom;
            mem_err    = ($urandom_range(0, 7) == 0);
            if ((n % 500) == 499) do_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Sits directly downstream of the processor core top.
- Merges the core's instruction-fetch port (req/gnt/rvalid) and data-access port into one shared memory port, for a single-ported SRAM or bus slave.
- Tracks the order of outstanding transactions so each response returns to the port that issued the request.
- Arbitration is combinational; response routing is held in an in-order ID FIFO.

Parameters:
- MAX_OUTSTANDING, 2, number of granted transactions allowed without a response (1..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_req_i  in  1  core fetch request
- instr_gnt_o  out  1  fetch request accepted
- instr_rvalid_o  out  1  fetch response valid
- instr_addr_i  in  32  fetch address
- instr_rdata_o  out  32  fetch data
- instr_err_o  out  1  fetch bus error, qualified by instr_rvalid_o
- data_req_i  in  1  core load/store request
- data_gnt_o  out  1  data request accepted
- data_rvalid_o  out  1  data response valid
- data_we_i  in  1  store when 1
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  store data
- data_rdata_o  out  32  load data
- data_err_o  out  1  data bus error, qualified by data_rvalid_o
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data
- mem_err_i  in  1  memory error
- protocol_err_o  out  1  sticky: set when mem_rvalid_i arrives with no transaction outstanding

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outstanding counter = 0; ID FIFO cleared; protocol_err_o = 0.
  - All grant and rvalid outputs = 0.
  - Round-robin pointer favours data.
  - Responses pending at reset are discarded. Any mem_rvalid_i after reset with the counter at 0 sets protocol_err_o.
- full = (count == MAX_OUTSTANDING).
- Arbitration (combinational, same cycle):
  - When full: mem_req_o = 0 and no grant is given.
  - Otherwise: winner = data if data_req_i and (fixed priority, or round-robin selects data); else instr if instr_req_i.
- mem_req_o = instr_req_i | data_req_i when not full.
- Address/control mux:
  - Data winner: mem_addr/we/be/wdata = data_*.
  - Instr winner: mem_addr_o = instr_addr_i, mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
- Grants:
  - data_gnt_o = mem_gnt_i & winner==data & mem_req_o.
  - instr_gnt_o likewise for instr.
  - The loser's gnt is 0. The loser keeps its request asserted, with stable address, per the req/gnt protocol.
- Push/pop:
  - Push: on mem_req_o & mem_gnt_i, push the winner ID (0 = instr, 1 = data) at the FIFO tail.
  - Pop: on mem_rvalid_i with count > 0, pop the head.
  - Push and pop in the same cycle leave the count unchanged; the new ID is written behind the popped entry.
- Response routing (combinational from mem_rvalid_i and the FIFO head):
  - instr_rvalid_o = mem_rvalid_i & count>0 & head==0.
  - data_rvalid_o = mem_rvalid_i & count>0 & head==1.
  - rdata_o and err_o of both ports carry mem_rdata_i / mem_err_i unconditionally; they are meaningful only with the port's rvalid.
- mem_rvalid_i when count==0: the response is dropped, no rvalid is asserted, protocol_err_o is set and held until reset.
- Latency:
  - Zero added cycles on the request path.
  - Zero added cycles on the response path.
  - Memory latency passes through unchanged.
- FIFO pointers wrap modulo MAX_OUTSTANDING; the count saturates logically through the full check and never exceeds MAX_OUTSTANDING.

Optional Feature:
- Macro: CORE_BUS_ARB_RR_EN.
- Defined:
  - Round-robin arbitration: when both request, the port not granted last wins.
  - The pointer updates only on an accepted grant (mem_req_o & mem_gnt_i).
  - A single requester always wins regardless of the pointer.
- Undefined: fixed priority, data always beats instr; no pointer register exists.

Test Plan:
- Reset, then instr_req=1, addr=0x80, mem_gnt=1 → instr_gnt=1, mem_we=0, mem_be=F. Next cycle rvalid=1, rdata=0x13 → instr_rvalid=1, instr_rdata=0x13, data_rvalid=0.
- Both request in the same cycle, data store addr=0x100, wdata=0xDEADBEEF, be=3 → fixed mode: data_gnt=1, instr_gnt=0, mem_we=1, mem_be=3. With CORE_BUS_ARB_RR_EN and both held for 4 grants → grants alternate data, instr, data, instr.
- MAX_OUTSTANDING=2: grant instr then data with no responses → third request sees mem_req=0 and no gnt. One rvalid → routed to instr; the next cycle's request is granted.
- Push and pop in the same cycle at count=1 → count stays 1. Responses return in order: instr then data.
- mem_rvalid=1 with nothing outstanding → no port rvalid; protocol_err_o=1, persisting until rst_n pulse clears it.
- rst_n asserted with 2 outstanding → count=0 and all outputs 0 immediately; a subsequent stray rvalid sets protocol_err_o.
